// File: rtl/pss_peak_detector.sv
// PSS peak detector: moving-average threshold trigger followed by a windowed local-max search.
// Optional post-search holdoff is built in when PSS_PEAK_DETECTOR_HOLDOFF_EN is defined.
module pss_peak_detector #(
    parameter int IN_DW           = 32,
    parameter int WINDOW_LEN      = 64,
    parameter int DETECTION_SHIFT = 4,
    parameter int SEARCH_LEN      = 8,
    parameter int HOLDOFF_LEN     = 128,
    parameter int CNT_DW          = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IN_DW-1:0]  s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    output logic [IN_DW-1:0]  m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    output logic [CNT_DW-1:0] peak_pos_o
);

    localparam int LOG2W   = $clog2(WINDOW_LEN);
    localparam int SUM_DW  = IN_DW + LOG2W;
    localparam int THR_DW  = IN_DW + DETECTION_SHIFT;
    localparam int SCNT_DW = $clog2(SEARCH_LEN + 1);
    localparam int WCNT_DW = $clog2(WINDOW_LEN + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
`ifdef PSS_PEAK_DETECTOR_HOLDOFF_EN
    localparam logic [1:0] S_HOLDOFF = 2'd2;
    localparam logic [1:0] S_AFTER   = S_HOLDOFF;
    localparam int         HCNT_DW   = $clog2(HOLDOFF_LEN + 1);
`else
    localparam logic [1:0] S_AFTER   = S_IDLE;
`endif

    if (WINDOW_LEN < 2 || (WINDOW_LEN & (WINDOW_LEN - 1)) != 0) begin : g_badWindowLen
        $error("pss_peak_detector: WINDOW_LEN must be a power of two >= 2");
    end
    if (SEARCH_LEN < 1) begin : g_badSearchLen
        $error("pss_peak_detector: SEARCH_LEN must be >= 1");
    end
    if (HOLDOFF_LEN < 1) begin : g_badHoldoffLen
        $error("pss_peak_detector: HOLDOFF_LEN must be >= 1");
    end

    logic [IN_DW-1:0]   r_buf [WINDOW_LEN];
    logic [LOG2W-1:0]   r_wrPtr;
    logic [SUM_DW-1:0]  r_sum;
    logic [CNT_DW-1:0]  r_index;
    logic [WCNT_DW-1:0] r_warmCnt;
    logic [1:0]         r_state;
    logic [SCNT_DW-1:0] r_searchCnt;
`ifdef PSS_PEAK_DETECTOR_HOLDOFF_EN
    logic [HCNT_DW-1:0] r_holdCnt;
`endif
    logic [IN_DW-1:0]   r_max;
    logic [CNT_DW-1:0]  r_maxPos;
    logic               r_outValid;
    logic [IN_DW-1:0]   r_outData;
    logic [CNT_DW-1:0]  r_outPos;

    logic [IN_DW-1:0]   w_avg;
    logic [THR_DW-1:0]  w_thresh;
    logic               w_warmDone;
    logic               w_trigger;
    logic               w_isNewMax;
    logic               w_keepMax;
    logic [IN_DW-1:0]   w_peakVal;
    logic [CNT_DW-1:0]  w_peakPos;
    logic               w_searchDone;

    // The average excludes the current sample, so it is taken from the sum before this beat's update.
    assign w_avg      = IN_DW'(r_sum >> LOG2W);
    assign w_thresh   = THR_DW'(w_avg) << DETECTION_SHIFT;
    assign w_warmDone = (r_warmCnt == WCNT_DW'(WINDOW_LEN));
    assign w_trigger  = s_axis_in_tvalid && w_warmDone && (THR_DW'(s_axis_in_tdata) > w_thresh);

    assign w_isNewMax = (s_axis_in_tdata > r_max);
    assign w_keepMax  = (r_state == S_SEARCH) && !w_isNewMax;
    assign w_peakVal  = w_keepMax ? r_max    : s_axis_in_tdata;
    assign w_peakPos  = w_keepMax ? r_maxPos : r_index;

    // A one-sample search window completes on the trigger beat itself.
    assign w_searchDone = ((r_state == S_IDLE) && w_trigger && (SEARCH_LEN == 1)) ||
                          ((r_state == S_SEARCH) && s_axis_in_tvalid &&
                           (r_searchCnt == SCNT_DW'(SEARCH_LEN - 1)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
                r_buf[i] <= '0;
            end
            r_wrPtr     <= '0;
            r_sum       <= '0;
            r_index     <= '0;
            r_warmCnt   <= '0;
            r_state     <= S_IDLE;
            r_searchCnt <= '0;
`ifdef PSS_PEAK_DETECTOR_HOLDOFF_EN
            r_holdCnt   <= '0;
`endif
            r_max       <= '0;
            r_maxPos    <= '0;
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outPos    <= '0;
        end else begin
            r_outValid <= 1'b0;
            if (s_axis_in_tvalid) begin
                r_buf[r_wrPtr] <= s_axis_in_tdata;
                r_wrPtr        <= r_wrPtr + LOG2W'(1);
                r_sum          <= r_sum + SUM_DW'(s_axis_in_tdata) - SUM_DW'(r_buf[r_wrPtr]);
                r_index        <= r_index + CNT_DW'(1);
                if (!w_warmDone) begin
                    r_warmCnt <= r_warmCnt + WCNT_DW'(1);
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_trigger) begin
                            r_max       <= s_axis_in_tdata;
                            r_maxPos    <= r_index;
                            r_searchCnt <= SCNT_DW'(1);
                            r_state     <= S_SEARCH;
                        end
                    end
                    S_SEARCH: begin
                        r_max       <= w_peakVal;
                        r_maxPos    <= w_peakPos;
                        r_searchCnt <= r_searchCnt + SCNT_DW'(1);
                    end
`ifdef PSS_PEAK_DETECTOR_HOLDOFF_EN
                    S_HOLDOFF: begin
                        if (r_holdCnt == HCNT_DW'(HOLDOFF_LEN - 1)) begin
                            r_holdCnt <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_holdCnt <= r_holdCnt + HCNT_DW'(1);
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase

                if (w_searchDone) begin
                    r_outValid <= 1'b1;
                    r_outData  <= w_peakVal;
                    r_outPos   <= w_peakPos;
                    r_state    <= S_AFTER;
`ifdef PSS_PEAK_DETECTOR_HOLDOFF_EN
                    r_holdCnt  <= '0;
`endif
                end
            end
        end
    end

    assign m_axis_out_tvalid = r_outValid;
    assign m_axis_out_tdata  = r_outData;
    assign peak_pos_o        = r_outPos;

endmodule

// File: tb/tb_pss_peak_detector.sv
// Table-driven bench for pss_peak_detector at default parameters.
// Holdoff expectations follow PSS_PEAK_DETECTOR_HOLDOFF_EN as seen by this compile.
module tb_pss_peak_detector;

    typedef struct {
        int numSamples;
        bit gaps;
        int spikeIdx[3];
        int spikeVal[3];
        int expCount;
        int expData[3];
        int expPos[3];
        int expAt[3];
    } vec_t;

    localparam int NUM_VECS = 6;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] s_axis_in_tdata = '0;
    logic        s_axis_in_tvalid = 1'b0;
    logic [31:0] m_axis_out_tdata;
    logic        m_axis_out_tvalid;
    logic [31:0] peak_pos_o;

    vec_t vecs[NUM_VECS];
    int   nChecks = 0;
    int   nFails = 0;
    int   acceptedCnt = 0;
    int   recN = 0;
    int   recData[8];
    int   recPos[8];
    int   recAt[8];

    pss_peak_detector dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axis_in_tdata  (s_axis_in_tdata),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .m_axis_out_tdata (m_axis_out_tdata),
        .m_axis_out_tvalid(m_axis_out_tvalid),
        .peak_pos_o       (peak_pos_o)
    );

    always #5 clk_i = ~clk_i;

    // Accepted-beat count lets a report be timed against the sample stream regardless of gaps.
    always @(posedge clk_i) begin
        if (reset_i) acceptedCnt = 0;
        else if (s_axis_in_tvalid) acceptedCnt = acceptedCnt + 1;
    end

    always @(negedge clk_i) begin
        if (m_axis_out_tvalid) begin
            if (recN < 8) begin
                recData[recN] = int'(m_axis_out_tdata);
                recPos[recN]  = int'(peak_pos_o);
                recAt[recN]   = acceptedCnt;
            end
            recN = recN + 1;
        end
    end

    task automatic applyStimulus(input logic [31:0] value, input logic valid);
        s_axis_in_tdata  = value;
        s_axis_in_tvalid = valid;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        applyStimulus(32'd0, 1'b0);
        applyStimulus(32'd0, 1'b0);
        reset_i = 1'b0;
        recN = 0;
    endtask

    task automatic setVec(input int i, input int n, input bit gaps,
                          input int s0, input int v0, input int s1, input int v1,
                          input int s2, input int v2, input int cnt);
        vecs[i].numSamples  = n;
        vecs[i].gaps        = gaps;
        vecs[i].spikeIdx[0] = s0;
        vecs[i].spikeVal[0] = v0;
        vecs[i].spikeIdx[1] = s1;
        vecs[i].spikeVal[1] = v1;
        vecs[i].spikeIdx[2] = s2;
        vecs[i].spikeVal[2] = v2;
        vecs[i].expCount    = cnt;
    endtask

    task automatic setExp(input int i, input int k, input int data, input int pos, input int at);
        vecs[i].expData[k] = data;
        vecs[i].expPos[k]  = pos;
        vecs[i].expAt[k]   = at;
    endtask

    task automatic streamVector(input int i);
        int value;
        for (int s = 0; s < vecs[i].numSamples; s++) begin
            if (vecs[i].gaps) begin
                while ($urandom_range(0, 2) == 0) applyStimulus(32'hDEAD_BEEF, 1'b0);
            end
            value = 100;
            for (int k = 0; k < 3; k++) begin
                if (vecs[i].spikeIdx[k] == s) value = vecs[i].spikeVal[k];
            end
            applyStimulus(32'(value), 1'b1);
        end
        for (int d = 0; d < 3; d++) applyStimulus(32'd0, 1'b0);
    endtask

    initial begin
        // Vector table: samples default to 100; each report gives data, index, and accepted-beat count at strobe.
        setVec(0, 90, 1'b0, 64, 1700, -1, 0, -1, 0, 1);
        setExp(0, 0, 1700, 64, 72);
        setVec(1, 90, 1'b0, 64, 1600, -1, 0, -1, 0, 0);
        setVec(2, 81, 1'b0, 10, 100000, -1, 0, -1, 0, 0);
        setVec(3, 90, 1'b0, 64, 1700, 66, 3000, 68, 3000, 1);
        setExp(3, 0, 3000, 66, 72);
`ifdef PSS_PEAK_DETECTOR_HOLDOFF_EN
        setVec(4, 230, 1'b0, 64, 1700, 150, 1700, 200, 5000, 2);
        setExp(4, 0, 1700, 64, 72);
        setExp(4, 1, 5000, 200, 208);
`else
        setVec(4, 230, 1'b0, 64, 1700, 150, 1700, 200, 5000, 3);
        setExp(4, 0, 1700, 64, 72);
        setExp(4, 1, 1700, 150, 158);
        setExp(4, 2, 5000, 200, 208);
`endif
        setVec(5, 90, 1'b1, 64, 1700, -1, 0, -1, 0, 1);
        setExp(5, 0, 1700, 64, 72);

        doReset();
        checkOutput("reset tvalid", int'(m_axis_out_tvalid), 0);
        checkOutput("reset tdata", int'(m_axis_out_tdata), 0);
        checkOutput("reset peak_pos", int'(peak_pos_o), 0);

        for (int i = 0; i < NUM_VECS; i++) begin
            doReset();
            streamVector(i);
            checkOutput($sformatf("v%0d report count", i), recN, vecs[i].expCount);
            for (int k = 0; k < vecs[i].expCount && k < recN && k < 8; k++) begin
                checkOutput($sformatf("v%0d r%0d tdata", i, k), recData[k], vecs[i].expData[k]);
                checkOutput($sformatf("v%0d r%0d peak_pos", i, k), recPos[k], vecs[i].expPos[k]);
                checkOutput($sformatf("v%0d r%0d strobe beat", i, k), recAt[k], vecs[i].expAt[k]);
            end
            if (vecs[i].expCount > 0) begin
                checkOutput($sformatf("v%0d held tdata", i), int'(m_axis_out_tdata),
                            vecs[i].expData[vecs[i].expCount - 1]);
                checkOutput($sformatf("v%0d held peak_pos", i), int'(peak_pos_o),
                            vecs[i].expPos[vecs[i].expCount - 1]);
            end else begin
                checkOutput($sformatf("v%0d idle tdata", i), int'(m_axis_out_tdata), 0);
            end
            checkOutput($sformatf("v%0d tvalid low", i), int'(m_axis_out_tvalid), 0);
        end

        // Reset lands on index 68, mid-search of the 1700 trigger at 64; then a spike during renewed warm-up.
        doReset();
        for (int s = 0; s < 68; s++) applyStimulus((s == 64) ? 32'd1700 : 32'd100, 1'b1);
        reset_i = 1'b1;
        applyStimulus(32'd100, 1'b1);
        reset_i = 1'b0;
        checkOutput("midsearch reset tdata", int'(m_axis_out_tdata), 0);
        for (int s = 0; s < 41; s++) applyStimulus((s == 30) ? 32'd100000 : 32'd100, 1'b1);
        for (int d = 0; d < 3; d++) applyStimulus(32'd0, 1'b0);
        checkOutput("midsearch reset report count", recN, 0);
        checkOutput("midsearch reset final tdata", int'(m_axis_out_tdata), 0);
        checkOutput("midsearch reset final peak_pos", int'(peak_pos_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pss_peak_detector.md
# pss_peak_detector

- Consumes the unsigned correlation-magnitude stream produced by the PSS correlator.
- Tracks a moving average of recent magnitudes and flags a PSS candidate when a sample exceeds that average by a configurable power-of-two factor.
- After a trigger, searches a short window for the true local maximum and reports the peak value and its absolute sample index as one output beat.
- Sits directly downstream of the correlator; feeds timing/frame-sync logic.

## Interface
Parameters:
- IN_DW, 32, width of unsigned correlator magnitude.
- WINDOW_LEN, 64, moving-average length in samples; power of two, ≥2.
- DETECTION_SHIFT, 4, threshold = average << DETECTION_SHIFT.
- SEARCH_LEN, 8, samples in peak-search window, trigger sample included; ≥1.
- HOLDOFF_LEN, 128, samples ignored after a search window; ≥1.
- CNT_DW, 32, width of sample index counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- s_axis_in_tdata  in  IN_DW  unsigned magnitude sample.
- s_axis_in_tvalid  in  1  sample valid; no back-pressure, every valid beat is accepted.
- m_axis_out_tdata  out  IN_DW  peak magnitude.
- m_axis_out_tvalid  out  1  single-cycle peak report strobe.
- peak_pos_o  out  CNT_DW  index of reported peak sample; qualified by m_axis_out_tvalid.

## Operation
- Sample index: counts accepted beats. The first beat after reset has index 0. The counter wraps modulo 2^CNT_DW.
- Average: running sum (width IN_DW+log2(WINDOW_LEN)) over a circular buffer of the last WINDOW_LEN accepted samples, not including the current one.
  - avg = sum >> log2(WINDOW_LEN), truncating.
  - Each beat adds the current sample and subtracts the oldest sample.
- Trigger condition, compared at width IN_DW+DETECTION_SHIFT: sample > (avg << DETECTION_SHIFT). The comparison is strict.
- Warm-up: triggers are suppressed until WINDOW_LEN samples have been accepted since reset, i.e. sample index ≥ WINDOW_LEN.
- State machine, advancing only on accepted beats:
  - IDLE: on trigger, latch sample and index as the running max, then go to SEARCH. The trigger sample counts as search sample 1.
  - SEARCH: update the max only if sample > max, so ties keep the earliest. After SEARCH_LEN samples total, emit the report and go to HOLDOFF.
  - HOLDOFF: ignore triggers for HOLDOFF_LEN samples, then return to IDLE.
- The average buffer updates on every accepted beat in all states.
- Gaps in s_axis_in_tvalid are transparent: the result depends only on the accepted sample sequence.

## Timing
- Reset values (applied on the cycle reset_i is sampled high):
  - State IDLE.
  - m_axis_out_tvalid=0, m_axis_out_tdata=0, peak_pos_o=0.
  - sum=0, buffer all zero, index=0, warm-up and state counters 0.
- Latency: the last search sample is accepted at cycle t; m_axis_out_tvalid=1 at cycle t+1 for exactly one cycle.
- m_axis_out_tdata and peak_pos_o hold the last reported values between strobes.
- A trigger-eligible sample arriving in the same beat the search completes is not evaluated; that beat is the last SEARCH sample.
- HOLDOFF starts on the beat after the last search sample. First trigger-eligible index = trigger index + SEARCH_LEN + HOLDOFF_LEN.
- Reset mid-SEARCH or mid-HOLDOFF: no report is emitted, and warm-up restarts.
- Index wrap during SEARCH: the reported peak_pos_o is the wrapped index; no special handling.

## Configuration
- Macro PSS_PEAK_DETECTOR_HOLDOFF_EN.
  - Defined: HOLDOFF state implemented as described.
  - Undefined: SEARCH returns directly to IDLE after the report. The next trigger may occur on the beat after the last search sample. HOLDOFF_LEN is ignored.

## Test plan
- Defaults throughout; indices 0-63 carry constant 100 unless stated.
- Basic peak: index 64 = 1700, all other samples 100.
  - Exactly one strobe, one cycle after index 71 is accepted.
  - tdata=1700, peak_pos_o=64.
- Threshold boundary: index 64 = 1600.
  - No strobe, because 1600 is not > 100<<4.
- Warm-up: index 10 = 100000.
  - No strobe through index 80.
- Local max and tie: index 64=1700, 66=3000, 68=3000.
  - Single report with tdata=3000, peak_pos_o=66.
- Holdoff, with macro defined: triggers at 64 and 150, then 5000 at 200.
  - Reports at pos 64 and 200 only.
  - With macro undefined, 150 is also reported.
- Reset and gaps:
  - Random tvalid gaps on the basic-peak stream give the same single report.
  - Asserting reset_i at the index 68 beat gives no report; outputs stay 0.
  - A spike at new index 30 is not reported.
